// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
// Power-up boot sequencer sitting between the UART receive buffer, the
// instruction memory write port and the core.
//   1. The first received word is a word count N.
//   2. The next N words are written to instruction memory at addresses 0..N-1.
//   3. cpu_start pulses for one cycle once the last write has been issued.
//   4. The receive stream is then passed straight through to the core.
// A count larger than the memory depth parks the block in a sticky error
// state. That state stops consuming words until reset.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   in_data/valid/ready  word stream from the receive buffer
//   imem_we/addr/wdata   instruction memory write port (registered)
//   cpu_start            one-cycle "program loaded" pulse
//   loading              high from reset through the cpu_start cycle
//   error                sticky: header count exceeds memory depth
//   cpu_in_data/valid    word stream to the core (valid only once running)
//   cpu_in_ready         core consumes the current word
module boot_loader_ctrl #(
  parameter int INST_MEM_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [31:0]               in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      imem_we,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic                      cpu_start,
  output logic                      loading,
  output logic                      error,
  output logic [31:0]               cpu_in_data,
  output logic                      cpu_in_valid,
  input  logic                      cpu_in_ready
);

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Memory depth as a 33-bit value, so that the comparison also covers 2**32.
  localparam logic [32:0] MEM_DEPTH = 33'(1) << INST_MEM_WIDTH;

  state_t                    r_state;
  logic [31:0]               r_remain;
  logic [INST_MEM_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic [INST_MEM_WIDTH-1:0] r_waddr;
  logic [31:0]               r_wdata;
  logic                      r_cpu_start;
  logic                      r_loading;
  logic                      r_error;

  logic w_xfer;
  logic w_too_big;

  assign w_xfer    = in_valid && in_ready;
  assign w_too_big = {1'b0, in_data} > MEM_DEPTH;

  // The ready signal is combinational. In RUN it mirrors the core's ready,
  // so words are never buffered here.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_HEADER: in_ready = 1'b1;
      ST_LOAD:   in_ready = 1'b1;
      ST_RUN:    in_ready = cpu_in_ready;
      default:   in_ready = 1'b0;
    endcase
  end

  assign cpu_in_data  = in_data;
  assign cpu_in_valid = (r_state == ST_RUN) && in_valid;

  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_start  = r_cpu_start;
  assign loading    = r_loading;
  assign error      = r_error;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_HEADER;
      r_remain    <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_start <= 1'b0;
      r_loading   <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      // Write enable and start are single-cycle strobes unless re-armed below.
      r_we        <= 1'b0;
      r_cpu_start <= 1'b0;
      case (r_state)
        ST_HEADER: begin
          if (w_xfer) begin
            r_addr   <= '0;
            r_remain <= in_data;
            if (in_data == 32'd0) begin
              r_state     <= ST_START;
              r_cpu_start <= 1'b1;
            end else if (w_too_big) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // Register the accepted word. The write appears on the port one
          // cycle after acceptance. With a full-depth load, the address
          // wraps to 0 after the last word, which is harmless.
          if (w_xfer) begin
            r_we     <= 1'b1;
            r_waddr  <= r_addr;
            r_wdata  <= in_data;
            r_addr   <= r_addr + INST_MEM_WIDTH'(1);
            r_remain <= r_remain - 32'd1;
            if (r_remain == 32'd1) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // The final write is on the port during this cycle.
          r_state     <= ST_START;
          r_cpu_start <= 1'b1;
        end
        ST_START: begin
          r_state   <= ST_RUN;
          r_loading <= 1'b0;
        end
        ST_RUN:   r_state <= ST_RUN;
        ST_ERROR: r_state <= ST_ERROR;
        default: begin
          r_state <= ST_HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl (INST_MEM_WIDTH = 4, depth 16).
// Each load is recorded as events: accept cycles, write cycles/addresses/data,
// start cycles and the first running cycle. These events are compared with
// the timing rules of the boot protocol, so the bench does not track the
// design's internal state.
module tb_boot_loader_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rstn;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_start;
  logic          loading;
  logic          error;
  logic [31:0]   cpu_in_data;
  logic          cpu_in_valid;
  logic          cpu_in_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] tx_q[$];

  boot_loader_ctrl #(.INST_MEM_WIDTH(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_start    (cpu_start),
    .loading      (loading),
    .error        (error),
    .cpu_in_data  (cpu_in_data),
    .cpu_in_valid (cpu_in_valid),
    .cpu_in_ready (cpu_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},     32'(imem_we), 32'd0);
    check_eq({tag, "_start"},  32'(cpu_start), 32'd0);
    check_eq({tag, "_error"},  32'(error), 32'd0);
    check_eq({tag, "_loading"}, 32'(loading), 32'd1);
    check_eq({tag, "_cpuv"},   32'(cpu_in_valid), 32'd0);
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    in_valid     = 1'b0;
    in_data      = 32'd0;
    cpu_in_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Sends tx_q (header followed by data words) with optional in_valid gaps.
  // gap_len < 0 selects random gaps of 0..3 cycles. When the queue is empty,
  // a blocker word is kept valid, so that any extra acceptance is visible.
  task automatic run_load(input int gap_len, input int max_cycles);
    logic [31:0] sent[$];
    int          acc_cyc[$];
    logic [31:0] acc_dat[$];
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_dat[$];
    int          start_cyc[$];
    int          first_run;
    int          gap_cnt;
    int          n;
    bit          bad_cpu_valid;
    bit          bad_err;
    int          exp_start;
    sent          = tx_q;
    n             = sent.size() - 1;
    first_run     = -1;
    gap_cnt       = 0;
    bad_cpu_valid = 1'b0;
    bad_err       = 1'b0;
    for (int t = 0; t < max_cycles; t++) begin
      @(posedge clk);
      #1;
      if (tx_q.size() > 0 && gap_cnt == 0) begin
        in_valid = 1'b1;
        in_data  = tx_q[0];
      end else if (tx_q.size() > 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        gap_cnt--;
      end else begin
        in_valid = 1'b1;
        in_data  = 32'h5555_0000 | 32'(t);
      end
      cpu_in_ready = 1'($urandom);
      #1;
      if (imem_we) begin
        wr_cyc.push_back(t);
        wr_addr.push_back(32'(imem_addr));
        wr_dat.push_back(imem_wdata);
      end
      if (cpu_start) start_cyc.push_back(t);
      if (cpu_in_valid && loading) bad_cpu_valid = 1'b1;
      if (error) bad_err = 1'b1;
      if (!loading && first_run < 0) first_run = t;
      if (in_valid && in_ready && loading) begin
        acc_cyc.push_back(t);
        acc_dat.push_back(in_data);
        if (tx_q.size() > 0) begin
          void'(tx_q.pop_front());
          gap_cnt = (gap_len < 0) ? int'($urandom_range(0, 3)) : gap_len;
        end
      end
      if (first_run >= 0 && t >= first_run + 2) break;
    end
    in_valid = 1'b0;
    tx_q.delete();

    check_eq("run_reached", 32'(first_run >= 0), 32'd1);
    check_eq("accept_count", 32'(acc_cyc.size()), 32'(n + 1));
    for (int i = 0; i < acc_dat.size() && i <= n; i++)
      check_eq($sformatf("accept_data[%0d]", i), acc_dat[i], sent[i]);
    check_eq("write_count", 32'(wr_cyc.size()), 32'(n));
    for (int i = 0; i < wr_cyc.size() && i < n; i++) begin
      check_eq($sformatf("write_addr[%0d]", i), wr_addr[i], 32'(i % DEPTH));
      check_eq($sformatf("write_data[%0d]", i), wr_dat[i], sent[i + 1]);
      if (i + 1 < acc_cyc.size())
        check_eq($sformatf("write_cycle[%0d]", i), 32'(wr_cyc[i]), 32'(acc_cyc[i + 1] + 1));
    end
    check_eq("start_count", 32'(start_cyc.size()), 32'd1);
    if (start_cyc.size() > 0 && acc_cyc.size() > n) begin
      exp_start = (n > 0) ? acc_cyc[n] + 2 : acc_cyc[0] + 1;
      check_eq("start_cycle", 32'(start_cyc[0]), 32'(exp_start));
      check_eq("loading_fall", 32'(first_run), 32'(start_cyc[0] + 1));
    end
    check_eq("cpu_valid_while_loading", 32'(bad_cpu_valid), 32'd0);
    check_eq("error_during_load", 32'(bad_err), 32'd0);
    $display("load N=%0d gap=%0d accepts=%0d writes=%0d start_at=%0d",
             n, gap_len, acc_cyc.size(), wr_cyc.size(),
             (start_cyc.size() > 0) ? start_cyc[0] : -1);
  endtask

  // Random pass-through traffic while in RUN.
  task automatic run_passthru(input int cycles);
    for (int t = 0; t < cycles; t++) begin
      @(posedge clk);
      #1;
      in_valid     = 1'($urandom);
      in_data      = $urandom;
      cpu_in_ready = 1'($urandom);
      #1;
      check_eq("run_data",  cpu_in_data, in_data);
      check_eq("run_valid", 32'(cpu_in_valid), 32'(in_valid));
      check_eq("run_ready", 32'(in_ready), 32'(cpu_in_ready));
      check_eq("run_quiet", 32'({imem_we, cpu_start, loading, error}), 32'd0);
    end
    in_valid = 1'b0;
    $display("passthru %0d cycles", cycles);
  endtask

  task automatic run_error(input logic [31:0] hdr);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = hdr;
    #1;
    check_eq("err_hdr_ready", 32'(in_ready), 32'd1);
    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      in_valid     = 1'b1;
      in_data      = $urandom;
      cpu_in_ready = 1'($urandom);
      #1;
      check_eq("err_flag",    32'(error), 32'd1);
      check_eq("err_ready",   32'(in_ready), 32'd0);
      check_eq("err_loading", 32'(loading), 32'd1);
      check_eq("err_quiet",   32'({imem_we, cpu_start, cpu_in_valid}), 32'd0);
    end
    in_valid = 1'b0;
    $display("error header 0x%08h", hdr);
  endtask

  initial begin
    int nw;
    rstn         = 1'b1;
    in_valid     = 1'b0;
    in_data      = 32'd0;
    cpu_in_ready = 1'b0;
    #2;
    do_reset();

    // Header 3, back-to-back data
    tx_q = '{32'd3, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    run_load(0, 100);
    run_passthru(10);

    // Header 2 with 5-cycle gaps
    do_reset();
    tx_q = '{32'd2, 32'h0000_0000, 32'h0000_0002};
    run_load(5, 100);

    // Header 0, then a stalled word in RUN
    do_reset();
    tx_q = '{32'd0};
    run_load(0, 50);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      in_valid     = 1'b1;
      in_data      = 32'h1234_5678;
      cpu_in_ready = (t == 3);
      #1;
      check_eq("stall_valid", 32'(cpu_in_valid), 32'd1);
      check_eq("stall_data",  cpu_in_data, 32'h1234_5678);
      check_eq("stall_ready", 32'(in_ready), 32'(t == 3));
    end
    $display("run stall word 0x12345678 released after 3 cycles");
    run_passthru(10);

    // Oversized headers
    do_reset();
    run_error(32'd17);
    do_reset();
    run_error(32'(DEPTH + 1) + $urandom_range(0, 100000));
    do_reset();
    run_error(32'hFFFF_FFFF);

    // Full-depth load
    do_reset();
    tx_q.push_back(32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) tx_q.push_back($urandom);
    run_load(-1, 400);

    // Reset during a load, then a fresh single-word load
    do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'd4;
    @(posedge clk);
    #1;
    in_data = 32'hC0DE_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check_eq("midload_we_before", 32'(imem_we), 32'd1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midload_async");
    $display("reset asserted mid-load");
    do_reset();
    tx_q = '{32'd1, 32'hDEAD_BEEF};
    run_load(0, 50);

    // Random loads
    for (int k = 0; k < 6; k++) begin
      do_reset();
      nw = $urandom_range(1, DEPTH);
      tx_q.push_back(32'(nw));
      for (int i = 0; i < nw; i++) tx_q.push_back($urandom);
      run_load(-1, 400);
      run_passthru(5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
